// File: rtl/batch_ram_sched.sv
// Address/strobe scheduler for the quad-segment sample RAM and ping-pong result RAM.
// Optional SCHED_ERR_EN adds a sticky err flag for in_valid pulses closer than min_gap clocks.
module batch_ram_sched #(
  parameter int seg_depth = 114,
  parameter int res_depth = 19,
  parameter int DSR2      = 6,
  parameter int min_gap   = 2,
  localparam int AW = $clog2(4*seg_depth),
  localparam int RW = $clog2(2*res_depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          sample_write,
  output logic [AW-1:0] sample_addr_in,
  output logic [AW-1:0] sample_addr_out1,
  output logic [AW-1:0] sample_addr_out2,
  output logic [AW-1:0] sample_addr_out3,
  output logic          res_write_b,
  output logic [RW-1:0] res_addr_in_b,
  output logic [RW-1:0] res_addr_out_b,
  output logic          seg_start,
  output logic          batch_valid,
  output logic          out_valid
`ifdef SCHED_ERR_EN
  ,
  output logic          err
`endif
);

  // sw_q | segment role
  // sw   | being written
  // sw+1 | oldest: forward/delay reads, ascending
  // sw+2 | backward-calc reads, descending
  // sw+3 | newest complete: lookahead reads, descending
  localparam int CW = (seg_depth > 1) ? $clog2(seg_depth) : 1;
  localparam int DW = (res_depth > 1) ? $clog2(res_depth) : 1;
  localparam int SW = (DSR2 > 1) ? $clog2(DSR2) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(seg_depth - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(DSR2 - 1);
  localparam logic [AW-1:0] SEG_D    = AW'(seg_depth);
  localparam logic [RW-1:0] RES_D    = RW'(res_depth);
  localparam logic [RW-1:0] RES_LAST = RW'(res_depth - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    sw_q, sw_d;
  logic          h_q, h_d;
  logic [2:0]    fill_q, fill_d;
  logic          sample_write_q, sample_write_d;
  logic [AW-1:0] addr_in_q, addr_in_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic          res_write_q, res_write_d;
  logic [RW-1:0] res_in_q, res_in_d, res_out_q, res_out_d;
  logic          seg_start_q, seg_start_d;
  logic          batch_valid_q, batch_valid_d;
  logic          out_valid_q, out_valid_d;

  logic [1:0]    sw_p1, sw_p2, sw_p3;
  logic [AW-1:0] cnt_up, cnt_dn;

  always_comb begin
    sw_p1 = sw_q + 2'd1;
    sw_p2 = sw_q + 2'd2;
    sw_p3 = sw_q + 2'd3;
    cnt_up = AW'(cnt_q);
    cnt_dn = AW'(CNT_LAST - cnt_q);

    cnt_d          = cnt_q;
    sub_d          = sub_q;
    div_d          = div_q;
    sw_d           = sw_q;
    h_d            = h_q;
    fill_d         = fill_q;
    sample_write_d = 1'b0;
    res_write_d    = 1'b0;
    seg_start_d    = 1'b0;
    addr_in_d      = addr_in_q;
    out1_d         = out1_q;
    out2_d         = out2_q;
    out3_d         = out3_q;
    res_in_d       = res_in_q;
    res_out_d      = res_out_q;
    batch_valid_d  = batch_valid_q;
    out_valid_d    = out_valid_q;

    if (in_valid) begin
      sample_write_d = 1'b1;
      seg_start_d    = (cnt_q == '0);
      addr_in_d      = AW'(sw_q)  * SEG_D + cnt_up;
      out1_d         = AW'(sw_p3) * SEG_D + cnt_dn;
      out2_d         = AW'(sw_p2) * SEG_D + cnt_dn;
      out3_d         = AW'(sw_p1) * SEG_D + cnt_up;
      res_in_d       = (h_q ? RES_D : '0) + (RES_LAST - RW'(div_q));
      res_out_d      = (h_q ? '0 : RES_D) + RW'(div_q);
      // fill_q counts completed segments, so the flags track the segment now being written
      res_write_d    = (sub_q == SUB_LAST) && (fill_q >= 3'd3);
      batch_valid_d  = batch_valid_q | (fill_q >= 3'd3);
      out_valid_d    = out_valid_q | (fill_q == 3'd4);

      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        sub_d  = '0;
        div_d  = '0;
        sw_d   = sw_p1;
        h_d    = ~h_q;
        fill_d = (fill_q < 3'd4) ? fill_q + 3'd1 : fill_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (sub_q == SUB_LAST) begin
          sub_d = '0;
          div_d = div_q + DW'(1);
        end else begin
          sub_d = sub_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      sub_q          <= '0;
      div_q          <= '0;
      sw_q           <= '0;
      h_q            <= 1'b0;
      fill_q         <= '0;
      sample_write_q <= 1'b0;
      addr_in_q      <= '0;
      out1_q         <= '0;
      out2_q         <= '0;
      out3_q         <= '0;
      res_write_q    <= 1'b0;
      res_in_q       <= '0;
      res_out_q      <= '0;
      seg_start_q    <= 1'b0;
      batch_valid_q  <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      sub_q          <= sub_d;
      div_q          <= div_d;
      sw_q           <= sw_d;
      h_q            <= h_d;
      fill_q         <= fill_d;
      sample_write_q <= sample_write_d;
      addr_in_q      <= addr_in_d;
      out1_q         <= out1_d;
      out2_q         <= out2_d;
      out3_q         <= out3_d;
      res_write_q    <= res_write_d;
      res_in_q       <= res_in_d;
      res_out_q      <= res_out_d;
      seg_start_q    <= seg_start_d;
      batch_valid_q  <= batch_valid_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign sample_write     = sample_write_q;
  assign sample_addr_in   = addr_in_q;
  assign sample_addr_out1 = out1_q;
  assign sample_addr_out2 = out2_q;
  assign sample_addr_out3 = out3_q;
  assign res_write_b      = res_write_q;
  assign res_addr_in_b    = res_in_q;
  assign res_addr_out_b   = res_out_q;
  assign seg_start        = seg_start_q;
  assign batch_valid      = batch_valid_q;
  assign out_valid        = out_valid_q;

`ifdef SCHED_ERR_EN
  localparam int GW = (min_gap > 0) ? $clog2(min_gap + 1) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(min_gap);

  // gap_q = clocks since the previous in_valid, saturating; starts saturated so the first pulse is clean
  logic [GW-1:0] gap_q, gap_d;
  logic          err_q, err_d;

  always_comb begin
    gap_d = gap_q;
    err_d = err_q;
    if (in_valid) begin
      gap_d = GW'(1);
      err_d = err_q | (gap_q < GAP_MAX);
    end else if (gap_q < GAP_MAX) begin
      gap_d = gap_q + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q <= GAP_MAX;
      err_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (min_gap > 0);
`endif

endmodule

// File: tb/tb_batch_ram_sched.sv
// Bench for batch_ram_sched: fixed vectors for the warm-up/rotation corners plus a
// randomized in_valid stream checked against a word-index reference model.
module tb_batch_ram_sched;
  localparam int SD = 6;
  localparam int RD = 2;
  localparam int DS = 3;
  localparam int MG = 2;
  localparam int AW = $clog2(4*SD);
  localparam int RW = $clog2(2*RD);

  logic          clk, rst, in_valid;
  logic          sample_write, res_write_b, seg_start, batch_valid, out_valid;
  logic [AW-1:0] sample_addr_in, sample_addr_out1, sample_addr_out2, sample_addr_out3;
  logic [RW-1:0] res_addr_in_b, res_addr_out_b;
`ifdef SCHED_ERR_EN
  logic          err;
`endif

  batch_ram_sched #(.seg_depth(SD), .res_depth(RD), .DSR2(DS), .min_gap(MG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .sample_write(sample_write), .sample_addr_in(sample_addr_in),
    .sample_addr_out1(sample_addr_out1), .sample_addr_out2(sample_addr_out2),
    .sample_addr_out3(sample_addr_out3), .res_write_b(res_write_b),
    .res_addr_in_b(res_addr_in_b), .res_addr_out_b(res_addr_out_b),
    .seg_start(seg_start), .batch_valid(batch_valid), .out_valid(out_valid)
`ifdef SCHED_ERR_EN
    , .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int wr; int a_in; int o1; int o2; int o3;
    int rw; int r_in; int r_out; int ss; int bv; int ov;
  } outs_t;

  typedef struct {
    int    word;
    outs_t e;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    n;
  int    cyc;
  int    last_v;
  bit    have_prev;
  int    err_m;
  outs_t last;
  outs_t zero_o;
  vec_t  tbl[8];

  function automatic vec_t mk(int w, int a, int o1, int o2, int o3, int rw, int ri, int ro,
                              int ss, int bv, int ov);
    vec_t v;
    v.word = w;
    v.e = '{wr:1, a_in:a, o1:o1, o2:o2, o3:o3, rw:rw, r_in:ri, r_out:ro, ss:ss, bv:bv, ov:ov};
    return v;
  endfunction

  // Expected outputs for the idx-th word (0-based) after reset.
  function automatic outs_t model_word(int idx);
    outs_t e;
    int seg, c, s, h, fill;
    seg  = idx / SD;
    c    = idx % SD;
    s    = seg % 4;
    h    = seg % 2;
    fill = (seg > 4) ? 4 : seg;
    e.wr    = 1;
    e.a_in  = s * SD + c;
    e.o1    = ((s + 3) % 4) * SD + (SD - 1 - c);
    e.o2    = ((s + 2) % 4) * SD + (SD - 1 - c);
    e.o3    = ((s + 1) % 4) * SD + c;
    e.r_in  = h * RD + (RD - 1 - c / DS);
    e.r_out = (1 - h) * RD + c / DS;
    e.ss    = (c == 0) ? 1 : 0;
    e.bv    = (fill >= 3) ? 1 : 0;
    e.ov    = (fill >= 4) ? 1 : 0;
    e.rw    = ((c % DS) == DS - 1 && e.bv == 1) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t word=%0d)", nm, act, exp, $time, n);
    end
  endtask

  task automatic cmp_all(input string tag, input outs_t e);
    chk({tag, ".sample_write"}, int'(sample_write), e.wr);
    chk({tag, ".sample_addr_in"}, int'(sample_addr_in), e.a_in);
    chk({tag, ".out1"}, int'(sample_addr_out1), e.o1);
    chk({tag, ".out2"}, int'(sample_addr_out2), e.o2);
    chk({tag, ".out3"}, int'(sample_addr_out3), e.o3);
    chk({tag, ".res_write_b"}, int'(res_write_b), e.rw);
    chk({tag, ".res_addr_in_b"}, int'(res_addr_in_b), e.r_in);
    chk({tag, ".res_addr_out_b"}, int'(res_addr_out_b), e.r_out);
    chk({tag, ".seg_start"}, int'(seg_start), e.ss);
    chk({tag, ".batch_valid"}, int'(batch_valid), e.bv);
    chk({tag, ".out_valid"}, int'(out_valid), e.ov);
`ifdef SCHED_ERR_EN
    chk({tag, ".err"}, int'(err), err_m);
`endif
  endtask

  task automatic model_reset();
    n         = 0;
    cyc       = 0;
    last_v    = 0;
    have_prev = 1'b0;
    err_m     = 0;
    last      = zero_o;
  endtask

  task automatic step(input bit v);
    outs_t e;
    @(negedge clk);
    in_valid = v;
    @(posedge clk);
    #1;
    cyc++;
    if (v) begin
      e = model_word(n);
      n++;
      if (have_prev && (cyc - last_v) < MG) err_m = 1;
      last_v    = cyc;
      have_prev = 1'b1;
    end else begin
      e    = last;
      e.wr = 0;
      e.rw = 0;
      e.ss = 0;
    end
    last = e;
    cmp_all("model", e);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    cmp_all(tag, zero_o);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int ti;
    int prev_a;
    zero_o = '{wr:0, a_in:0, o1:0, o2:0, o3:0, rw:0, r_in:0, r_out:0, ss:0, bv:0, ov:0};
    tbl[0] = mk(1,   0, 23, 17,  6, 0, 1, 2, 1, 0, 0);
    tbl[1] = mk(7,   6,  5, 23, 12, 0, 3, 0, 1, 0, 0);
    tbl[2] = mk(18, 17,  6,  0, 23, 0, 0, 3, 0, 0, 0);
    tbl[3] = mk(19, 18, 17, 11,  0, 0, 3, 0, 1, 1, 0);
    tbl[4] = mk(21, 20, 15,  9,  2, 1, 3, 0, 0, 1, 0);
    tbl[5] = mk(24, 23, 12,  6,  5, 1, 2, 1, 0, 1, 0);
    tbl[6] = mk(25,  0, 23, 17,  6, 0, 1, 2, 1, 1, 1);
    tbl[7] = mk(27,  2, 21, 15,  8, 1, 1, 2, 0, 1, 1);

    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    cmp_all("por", zero_o);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int w = 0; w < 9; w++) begin
      step(1'b1);
      step(1'b0);
    end
    do_reset("midreset");

    ti = 0;
    for (int w = 1; w <= 28; w++) begin
      step(1'b1);
      if (ti < 8 && tbl[ti].word == w) begin
        cmp_all($sformatf("tbl_w%0d", w), tbl[ti].e);
        ti++;
      end
      step(1'b0);
    end
    chk("tbl_rows_used", ti, 8);

    prev_a = last.a_in;
    repeat (10) step(1'b0);
    step(1'b1);
    chk("idle_resume_addr", int'(sample_addr_in), prev_a + 1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset("rand_reset");
      else step($urandom_range(0, 2) == 0);
    end

    do_reset("b2b_reset");
    step(1'b1);
    chk("b2b_first_addr", int'(sample_addr_in), 0);
    step(1'b1);
    chk("b2b_second_addr", int'(sample_addr_in), 1);
`ifdef SCHED_ERR_EN
    chk("b2b_err_set", int'(err), 1);
    repeat (4) step(1'b0);
    chk("b2b_err_sticky", int'(err), 1);
    do_reset("err_clear");
`endif
    step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
